iic_req_arbiter: RTL and testbench
==================================

Name: iic_req_arbiter

Overview:
- Shares one `iic` master core between two independent requesters (ch0, ch1).
- Round-robin arbitration between ch0 and ch1.
- Sequences one complete byte transaction on the core per grant: drive command, wait for completion, return read data.
- Sits between system-side clients and the `iic` core, inside the IIC top level.

Parameters:
- ADDR_16BIT, 1, value driven on iic_add_bit; 1 = 16-bit word address, 0 = 8-bit.
- TIMEOUT_CYC, 2_000_000, sys_clk cycles allowed per transaction; used only with IIC_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous reset, active-low
- req0  in  1  ch0 request; level, held until done0
- rw0  in  1  ch0 direction; 1 = read, 0 = write
- addr0  in  16  ch0 word address
- wdata0  in  8  ch0 write data
- done0  out  1  ch0 completion pulse, 1 cycle
- req1, rw1, addr1, wdata1, done1  as ch0, for ch1
- rd_data  out  8  read data of the last completed read; valid with done0/done1
- busy  out  1  high while a transaction is in flight
- err  out  1  timeout flag, 1 cycle with done (only with IIC_TIMEOUT_EN; tied 0 otherwise)
- iic_add_bit  out  1  to core
- iic_wr_en  out  1  to core; 1-cycle start pulse
- iic_rd_en  out  1  to core; 1-cycle start pulse
- iic_word_add  out  16  to core
- iic_wr_data  out  8  to core
- iic_rd_data  in  8  from core
- iic_end  in  1  from core; 1-cycle pulse when the transaction (incl. STOP) finishes

Behaviour:
- Reset values: done0 = done1 = 0, rd_data = 0, busy = 0, err = 0, iic_wr_en = iic_rd_en = 0, iic_word_add = 0, iic_wr_data = 0, last-grant = ch1 (so ch0 wins first contention).
- iic_add_bit = ADDR_16BIT at all times.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - Only one of req0/req1 high: grant that channel.
  - Both high: grant the channel not granted last.
  - On grant, latch rw/addr/wdata of the granted channel into iic_word_add/iic_wr_data and a rw register; record the granted channel; go to START.
- START (1 cycle): assert iic_rd_en if rw = 1, else iic_wr_en; go to WAIT.
- WAIT: hold command registers stable; on iic_end, capture iic_rd_data into rd_data if rw = 1 (rd_data unchanged on writes); go to DONE.
- DONE (1 cycle): pulse done of the granted channel; update last-grant; go to IDLE.
- busy = 1 in START, WAIT and DONE.
- Latency:
  - Request-to-start: 2 cycles (grant edge in IDLE, iic_*_en high in the cycle after).
  - iic_end-to-done: 1 cycle.
  - Earliest next grant: cycle after DONE.
- Requests are not re-sampled after grant. Requester changes to addr/wdata/rw mid-transaction have no effect.
- Dropping a req while it is granted does not abort; done still pulses.
- A requester keeping req high after done is re-granted only per round-robin (no back-to-back starvation of the other channel).
- iic_end in IDLE, START or DONE is ignored.
- Asynchronous reset mid-transaction: FSM returns to IDLE, all outputs return to reset values; the core is reset by the same signal.

Optional Feature:
- Macro: IIC_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYC - 1 without iic_end, go to DONE with err = 1 for the done cycle; rd_data unchanged.
  - Counter clears on each grant.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- ch0-only write: req0 = 1, rw0 = 0, addr0 = 16'h0010, wdata0 = 8'hA5.
  - Expect one iic_wr_en pulse 2 cycles after req0 rise, iic_word_add = 16'h0010, iic_wr_data = 8'hA5.
  - Bench model asserts iic_end; expect done0 1 cycle later, rd_data unchanged.
- ch1-only read: req1 = 1, rw1 = 1, addr1 = 16'h0003; model returns 8'h5C with iic_end.
  - Expect iic_rd_en pulse, rd_data = 8'h5C together with a 1-cycle done1, done0 = 0.
- Contention after reset: req0 and req1 rise in the same cycle.
  - Expect ch0 served first, then ch1.
  - With both held high, grants alternate 0,1,0,1 over 4 transactions.
- Mid-transaction changes: change addr0 to 16'hFFFF and drop req0 during WAIT.
  - Expect iic_word_add stays at the latched value, done0 still pulses, no second start.
- Reset during WAIT: assert sys_rst_n = 0.
  - Expect busy = 0, iic_*_en = 0, rd_data = 0 immediately.
  - After release, a new req0 starts normally.
- IIC_TIMEOUT_EN with TIMEOUT_CYC = 100 and no iic_end: expect done0 with err = 1 exactly 100 cycles after entering WAIT (+1 for DONE), then IDLE.

Source files
------------

// File: rtl/iic_req_arbiter_if.sv
// Client and core-side signal bundle of iic_req_arbiter.
// The arbiter takes the slave modport; the environment (clients and core) takes master.
interface iic_req_arbiter_if;
    logic        req0;
    logic        rw0;
    logic [15:0] addr0;
    logic [7:0]  wdata0;
    logic        done0;
    logic        req1;
    logic        rw1;
    logic [15:0] addr1;
    logic [7:0]  wdata1;
    logic        done1;
    logic [7:0]  rd_data;
    logic        busy;
    logic        err;
    logic        iic_add_bit;
    logic        iic_wr_en;
    logic        iic_rd_en;
    logic [15:0] iic_word_add;
    logic [7:0]  iic_wr_data;
    logic [7:0]  iic_rd_data;
    logic        iic_end;

    modport slave (
        input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, iic_rd_data, iic_end,
        output done0, done1, rd_data, busy, err,
        output iic_add_bit, iic_wr_en, iic_rd_en, iic_word_add, iic_wr_data
    );

    modport master (
        output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, iic_rd_data, iic_end,
        input  done0, done1, rd_data, busy, err,
        input  iic_add_bit, iic_wr_en, iic_rd_en, iic_word_add, iic_wr_data
    );
endinterface

// File: rtl/iic_req_arbiter.sv
// Round-robin arbiter sharing one iic master core between two byte-transaction requesters.
// Optional macro IIC_TIMEOUT_EN adds a per-transaction watchdog that ends WAIT with err.
module iic_req_arbiter #(
    parameter bit          ADDR_16BIT  = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    iic_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err_q, err_d;
    logic        timeout;

`ifdef IIC_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Idle clears the count, so every grant starts the watchdog from zero.
    always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                timeout = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    // On contention the channel not served last wins.
                    gnt_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    rw_d    = gnt_d ? bus.rw1    : bus.rw0;
                    addr_d  = gnt_d ? bus.addr1  : bus.addr0;
                    wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
                    wr_en_d = ~rw_d;
                    rd_en_d = rw_d;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.iic_end) begin
                    if (rw_q) begin
                        rdata_d = bus.iic_rd_data;
                    end
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    state_d = StDone;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
        end
    end

    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.rd_data      = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.iic_add_bit  = ADDR_16BIT;
    assign bus.iic_wr_en    = wr_en_q;
    assign bus.iic_rd_en    = rd_en_q;
    assign bus.iic_word_add = addr_q;
    assign bus.iic_wr_data  = wdata_q;

endmodule

// File: tb/tb_iic_req_arbiter.sv
// Self-checking bench for iic_req_arbiter: directed steps plus randomized traffic against
// a round-robin reference model; the timeout section runs only with IIC_TIMEOUT_EN.
module tb_iic_req_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    always #5 sys_clk = ~sys_clk;

    iic_req_arbiter_if bus ();

    iic_req_arbiter #(
        .ADDR_16BIT  (1'b1),
        .TIMEOUT_CYC (100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: channel served last and the last read byte returned.
    bit         exp_last = 1'b1;
    logic [7:0] exp_rd   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one full transaction from IDLE with the current requests; returns in IDLE.
    task automatic xact(input int lat, input logic [7:0] rdv, input bit poke, input bit glitch);
        bit          g;
        bit          rw;
        logic [15:0] a;
        logic [7:0]  w;
        g  = (bus.req0 && bus.req1) ? !exp_last : bus.req1;
        rw = g ? bus.rw1 : bus.rw0;
        a  = g ? bus.addr1 : bus.addr0;
        w  = g ? bus.wdata1 : bus.wdata0;
        tick();
        chk("busy_start", bus.busy, 1);
        chk("wr_en_start", bus.iic_wr_en, !rw);
        chk("rd_en_start", bus.iic_rd_en, rw);
        chk("word_add", bus.iic_word_add, a);
        chk("wr_data", bus.iic_wr_data, w);
        if (glitch) begin
            bus.iic_end     = 1'b1;
            bus.iic_rd_data = 8'hEE;
        end
        tick();
        bus.iic_end = 1'b0;
        chk("en_wait", {bus.iic_wr_en, bus.iic_rd_en}, 0);
        chk("no_done_wait", {bus.done0, bus.done1}, 0);
        if (poke) begin
            if (g) begin
                bus.addr1 = 16'hFFFF; bus.wdata1 = ~w; bus.rw1 = !rw; bus.req1 = 1'b0;
            end else begin
                bus.addr0 = 16'hFFFF; bus.wdata0 = ~w; bus.rw0 = !rw; bus.req0 = 1'b0;
            end
        end
        repeat (lat) begin
            tick();
            chk("no_done_lat", {bus.done0, bus.done1}, 0);
        end
        bus.iic_rd_data = rdv;
        bus.iic_end     = 1'b1;
        tick();
        bus.iic_end     = glitch;
        bus.iic_rd_data = 8'hEE;
        if (rw) exp_rd = rdv;
        chk("done0", bus.done0, !g);
        chk("done1", bus.done1, g);
        chk("rd_data", bus.rd_data, exp_rd);
        chk("err", bus.err, 0);
        chk("word_add_held", bus.iic_word_add, a);
        exp_last = g;
        tick();
        bus.iic_end = 1'b0;
        chk("done_clear", {bus.done0, bus.done1}, 0);
        chk("busy_idle", bus.busy, 0);
        chk("rd_data_idle", bus.rd_data, exp_rd);
    endtask

    initial begin
        sys_rst_n       = 1'b0;
        bus.req0        = 1'b0; bus.rw0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1        = 1'b0; bus.rw1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.iic_rd_data = '0;
        bus.iic_end     = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        chk("rst_done", {bus.done0, bus.done1}, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_en", {bus.iic_wr_en, bus.iic_rd_en}, 0);
        chk("rst_word_add", bus.iic_word_add, 0);
        chk("rst_wr_data", bus.iic_wr_data, 0);
        chk("add_bit", bus.iic_add_bit, 1);

        // ch0-only write
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'h0010; bus.wdata0 = 8'hA5;
        xact(3, 8'h77, 1'b0, 1'b0);
        bus.req0 = 1'b0;

        // ch1-only read
        bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 16'h0003; bus.wdata1 = 8'h00;
        xact(2, 8'h5C, 1'b0, 1'b0);
        bus.req1 = 1'b0;

        // Stray iic_end while idle is ignored.
        bus.iic_end = 1'b1; bus.iic_rd_data = 8'h99;
        tick();
        bus.iic_end = 1'b0;
        tick();
        chk("idle_end_busy", bus.busy, 0);
        chk("idle_end_done", {bus.done0, bus.done1}, 0);
        chk("idle_end_rd", bus.rd_data, exp_rd);

        // Reset-contention style: both held high alternate 0,1,0,1.
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h1111; bus.wdata0 = 8'h11;
        bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 16'h2222; bus.wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) xact(i, 8'(8'h30 + i), 1'b0, 1'b0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // iic_end in START and DONE ignored; mid-transaction changes have no effect.
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h0042; bus.wdata0 = 8'h3C;
        xact(4, 8'hB7, 1'b1, 1'b1);
        tick();
        chk("no_restart_busy", bus.busy, 0);
        chk("no_restart_en", {bus.iic_wr_en, bus.iic_rd_en}, 0);

        // Asynchronous reset during WAIT.
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h1234; bus.wdata0 = 8'h56;
        tick();
        tick();
        tick();
        sys_rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_en", {bus.iic_wr_en, bus.iic_rd_en}, 0);
        chk("arst_rd_data", bus.rd_data, 0);
        chk("arst_word_add", bus.iic_word_add, 0);
        bus.req0 = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        exp_last  = 1'b1;
        exp_rd    = 8'h00;
        tick();
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'hBEEF; bus.wdata0 = 8'hC3;
        xact(1, 8'h10, 1'b0, 1'b0);
        bus.req0 = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 24; i++) begin
            logic [1:0] pat;
            pat        = 2'($urandom_range(1, 3));
            bus.req0   = pat[0];
            bus.req1   = pat[1];
            bus.rw0    = 1'($urandom);
            bus.rw1    = 1'($urandom);
            bus.addr0  = 16'($urandom);
            bus.addr1  = 16'($urandom);
            bus.wdata0 = 8'($urandom);
            bus.wdata1 = 8'($urandom);
            xact(int'($urandom_range(0, 6)), 8'($urandom), 1'b0, 1'b0);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

`ifdef IIC_TIMEOUT_EN
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h0ABC; bus.wdata0 = 8'h00;
        tick();
        bus.req0 = 1'b0;
        tick();
        for (int i = 0; i < 99; i++) begin
            tick();
            chk("to_no_done", {bus.done0, bus.done1, bus.err}, 0);
        end
        tick();
        chk("to_done0", bus.done0, 1);
        chk("to_err", bus.err, 1);
        chk("to_rd_data", bus.rd_data, exp_rd);
        exp_last = 1'b0;
        tick();
        chk("to_idle", {bus.busy, bus.err, bus.done0}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
